control_plane_responder: RTL and testbench
==========================================

# control_plane_responder

Target-side endpoint for the control-plane request channel: it accepts single-beat read/write requests, services them against a small local register window after a programmable number of wait states, and returns one response per request on a valid/ready response channel. It is the responder counterpart to the control-plane initiator driven by the bench's `control_plane_in` agent, and sits at the control-plane edge of block_a/block_b. Out-of-window accesses are answered with an error, never dropped.

## Interface
- `CP_IN_DATA_WIDTH`, default 28: request write-data and response read-data width.
- `CP_IN_ADDR_WIDTH`, default 37: request address width.
- `NUM_REGS`, default 8: number of local registers; must be ≥1, power of two not required.
- `BASE_ADDR`, default 0: first address of the register window.
- `WAIT_CYCLES`, default 2: wait states inserted before each response; 0..255.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in CP_IN_ADDR_WIDTH: request address.
- `req_wdata` in CP_IN_DATA_WIDTH: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: downstream accepts response.
- `rsp_wr` out 1: echo of captured `req_wr`.
- `rsp_rdata` out CP_IN_DATA_WIDTH: read data; 0 for writes and errors.
- `rsp_err` out 1: address outside window.
- `cfg_reg0` out CP_IN_DATA_WIDTH: live value of register 0.
- `err_count` out 8: saturating count of error responses.

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`: capture wr/addr/wdata; load wait counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else execute and go RESP.
- WAIT: `req_ready`=0. If counter==1: execute, go RESP; else decrement.
- Execute (on the edge entering RESP): hit = BASE_ADDR ≤ addr < BASE_ADDR+NUM_REGS, compared at full CP_IN_ADDR_WIDTH with no wrap (window end computed one bit wider). Index = addr−BASE_ADDR.
  - Write hit: reg[index] ← wdata; rsp_rdata=0, rsp_err=0.
  - Read hit: rsp_rdata=reg[index], rsp_err=0.
  - Miss: no register change; rsp_rdata=0, rsp_err=1; err_count increments, saturating at 255.
- RESP: `rsp_valid`=1; rsp_* held stable until `rsp_ready`; on handshake go IDLE.
- `req_*` are ignored outside IDLE; `req_valid` held high during WAIT/RESP is not a new request until `req_ready` is seen.
- Exactly one response per accepted request, in order (single outstanding request).

## Timing
- Reset values: req_ready=0 during reset, 1 in first cycle after release; rsp_valid=0, rsp_wr=0, rsp_rdata=0, rsp_err=0, cfg_reg0=0, err_count=0; all registers 0; counter 0.
- Latency: request handshake in cycle c → rsp_valid first high in cycle c+WAIT_CYCLES+1.
- Write visibility: register and cfg_reg0 update on the same edge rsp_valid rises.
- Throughput: response handshake in cycle d → req_ready high in d+1; minimum request spacing WAIT_CYCLES+2 cycles with rsp_ready tied high.
- Backpressure: rsp_ready low holds RESP indefinitely; outputs unchanged.
- Reset asserted mid-WAIT or mid-RESP: pending request and response discarded, registers and err_count cleared immediately; no response emitted after release.
- err_count at 255 plus further miss: stays 255.

## Test plan
- Reset release: all outputs at reset values; req_ready=1 one cycle after release; cfg_reg0=0.
- Write addr=BASE_ADDR+0, data=28'hABCDEF1, then read it (WAIT_CYCLES=2, rsp_ready=1) → write rsp_valid at c+3 with rsp_wr=1, rdata=0, err=0; cfg_reg0=28'hABCDEF1; read returns 28'hABCDEF1.
- Read addr=BASE_ADDR+NUM_REGS and addr=37'h1F_FFFF_FFFF → rsp_err=1, rdata=0, err_count 0→1→2; no register changes.
- Hold rsp_ready=0 for 10 cycles in RESP with req_valid=1 → req_ready stays 0, response fields stable; release → IDLE next cycle, then new request accepted.
- WAIT_CYCLES=0 build: back-to-back writes to regs 0..7 with data=index → each rsp_valid one cycle after accept; reads return 0..7.
- Assert rst during WAIT of a write to reg 3 → no response after release, reg 3 reads 0; 260 misses → err_count saturates at 255.

Source files
------------

// File: rtl/control_plane_responder.sv
// control_plane_responder: control-plane target that answers single-beat read/write
// requests against a small local register window after WAIT_CYCLES wait states.
//   clk, rst                    : clock, asynchronous active-high reset
//   req_valid/req_ready         : request handshake; req_wr/req_addr/req_wdata payload
//   rsp_valid/rsp_ready         : response handshake; rsp_wr/rsp_rdata/rsp_err payload
//   cfg_reg0                    : live value of register 0
//   err_count                   : saturating count of error responses
module control_plane_responder #(
    parameter int                          CP_IN_DATA_WIDTH = 28,
    parameter int                          CP_IN_ADDR_WIDTH = 37,
    parameter int                          NUM_REGS         = 8,
    parameter logic [CP_IN_ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                          WAIT_CYCLES      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [CP_IN_ADDR_WIDTH-1:0] req_addr,
    input  logic [CP_IN_DATA_WIDTH-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_wr,
    output logic [CP_IN_DATA_WIDTH-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic [CP_IN_DATA_WIDTH-1:0] cfg_reg0,
    output logic [7:0]                  err_count
);
    localparam int AW = CP_IN_ADDR_WIDTH;
    localparam int DW = CP_IN_DATA_WIDTH;
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
    localparam logic [AW:0] NUM_EXT   = (AW+1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rsp_wr_q, rsp_wr_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic [DW-1:0]   regs_d [NUM_REGS];

    logic            accept, ex_en, ex_wr, hit;
    logic [AW-1:0]   ex_addr;
    logic [DW-1:0]   ex_wdata, rd_val;
    logic [AW:0]     off;

    // Ready is held low while reset is asserted even though the state already reads IDLE.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cfg_reg0  = regs_q[0];
    assign err_count = err_count_q;

    always_comb begin
        // With zero wait states the request executes straight from the input pins.
        ex_wr    = (state_q == IDLE) ? req_wr    : wr_q;
        ex_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        ex_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        ex_en    = (state_q == IDLE) ? (accept && WAIT_CYCLES == 0)
                                     : (state_q == WAIT && cnt_q == 8'd1);
        // One bit wider: an address below the base borrows into the top bit and misses.
        off      = {1'b0, ex_addr} - {1'b0, BASE_ADDR};
        hit      = off < NUM_EXT;
        rd_val   = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (off == (AW+1)'(i)) rd_val = regs_q[i];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        regs_d      = regs_q;
        if (state_q == IDLE) begin
            if (accept) begin
                wr_d    = req_wr;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = WAIT_INIT;
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = rsp_ready ? IDLE : RESP;
        end
        if (ex_en) begin
            rsp_wr_d    = ex_wr;
            rsp_rdata_d = (hit && !ex_wr) ? rd_val : '0;
            rsp_err_d   = !hit;
            err_count_d = (!hit && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
            for (int i = 0; i < NUM_REGS; i++)
                if (hit && ex_wr && off == (AW+1)'(i)) regs_d[i] = ex_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
            regs_q      <= regs_d;
        end
    end
endmodule

// File: tb/tb_control_plane_responder.sv
// tb_control_plane_responder: randomized and directed checks of control_plane_responder
// against a register-window reference model (WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 one).
module tb_control_plane_responder;
    localparam int      W    = 2;
    localparam int      NR   = 8;
    localparam longint  BASE = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_wr = 0, rsp_ready = 1;
    logic [36:0] req_addr = '0;
    logic [27:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_wr, rsp_err;
    logic [27:0] rsp_rdata, cfg_reg0;
    logic [7:0]  err_count;

    logic        z_req_valid = 0, z_req_wr = 0, z_rsp_ready = 1;
    logic [36:0] z_req_addr = '0;
    logic [27:0] z_req_wdata = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_wr, z_rsp_err;
    logic [27:0] z_rsp_rdata, z_cfg_reg0;
    logic [7:0]  z_err_count;

    control_plane_responder #(.CP_IN_DATA_WIDTH(28), .CP_IN_ADDR_WIDTH(37), .NUM_REGS(NR),
                              .BASE_ADDR(37'(BASE)), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cfg_reg0(cfg_reg0),
        .err_count(err_count));

    control_plane_responder #(.CP_IN_DATA_WIDTH(28), .CP_IN_ADDR_WIDTH(37), .NUM_REGS(NR),
                              .BASE_ADDR(37'(BASE)), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wr(z_req_wr),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready), .rsp_wr(z_rsp_wr), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .cfg_reg0(z_cfg_reg0), .err_count(z_err_count));

    logic [27:0] m_regs [NR];
    int          m_err = 0;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_err = 0;
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance; hold>0 keeps rsp_ready low that many
    // cycles while req_valid stays asserted.
    task automatic txn(input logic wr, input logic [36:0] addr, input logic [27:0] wd, input int hold);
        longint unsigned a = 64'(addr);
        bit              h = (a >= BASE) && (a < BASE + NR);
        logic [27:0]     exp_rd, s_rd;
        logic            s_err, s_wr;
        int              n;
        exp_rd = (h && !wr) ? m_regs[a - BASE] : 28'h0;
        @(negedge clk);
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", 64'(n < 20), 1);
        @(posedge clk); #1;
        if (hold == 0) req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        chk("latency", 64'(n), 64'(W + 1));
        if (h && wr) m_regs[a - BASE] = wd;
        if (!h && m_err < 255) m_err++;
        chk("rsp_wr", 64'(rsp_wr), 64'(wr));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("rsp_err", 64'(rsp_err), 64'(!h));
        chk("cfg_reg0", 64'(cfg_reg0), 64'(m_regs[0]));
        chk("err_count", 64'(err_count), 64'(m_err));
        s_rd = rsp_rdata; s_err = rsp_err; s_wr = rsp_wr;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 0);
            chk("bp_rsp_valid", 64'(rsp_valid), 1);
            chk("bp_stable", {s_wr, s_err, s_rd}, {rsp_wr, rsp_err, rsp_rdata});
        end
        rsp_ready = 1;
        @(negedge clk);
        req_valid = 0;
        chk("ready_after_rsp", 64'(req_ready), 1);
        chk("valid_after_rsp", 64'(rsp_valid), 0);
    endtask

    // Zero-wait-state instance: response must be up the cycle after acceptance.
    task automatic ztxn(input logic wr, input logic [36:0] addr, input logic [27:0] wd,
                        input logic [27:0] exp_rd);
        int n;
        @(negedge clk);
        z_req_valid = 1; z_req_wr = wr; z_req_addr = addr; z_req_wdata = wd;
        n = 0;
        while (!z_req_ready && n < 20) begin @(negedge clk); n++; end
        chk("z_spacing", 64'(n), 0);
        @(posedge clk); #1;
        z_req_valid = 0;
        @(negedge clk);
        chk("z_rsp_valid", 64'(z_rsp_valid), 1);
        chk("z_rsp_wr", 64'(z_rsp_wr), 64'(wr));
        chk("z_rsp_rdata", 64'(z_rsp_rdata), 64'(exp_rd));
        chk("z_rsp_err", 64'(z_rsp_err), 0);
    endtask

    initial begin
        logic [63:0] r64;
        logic [36:0] addr;
        int          n;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        rst = 0;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready), 1);
        chk("rel_outputs", {rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 0);
        chk("rel_cfg_reg0", 64'(cfg_reg0), 0);
        chk("rel_err_count", 64'(err_count), 0);

        txn(1, 37'(BASE), 28'hABCDEF1, 0);
        chk("cfg_abc", 64'(cfg_reg0), 64'(28'hABCDEF1));
        txn(0, 37'(BASE), 28'h0, 0);
        txn(0, 37'(BASE + NR), 28'h0, 0);
        chk("err_cnt_1", 64'(err_count), 1);
        txn(0, 37'h1F_FFFF_FFFF, 28'h0, 0);
        chk("err_cnt_2", 64'(err_count), 2);
        chk("miss_no_change", 64'(cfg_reg0), 64'(28'hABCDEF1));

        txn(0, 37'(BASE), 28'h0, 10);
        txn(1, 37'(BASE + 5), 28'h1234567, 0);
        txn(0, 37'(BASE + 5), 28'h0, 0);

        for (int i = 0; i < 60; i++) begin
            r64 = {32'($urandom), 32'($urandom)};
            addr = ($urandom_range(0, 3) == 0) ? r64[36:0] : 37'(BASE + $urandom_range(0, NR + 3));
            txn(1'($urandom_range(0, 1)), addr, 28'($urandom), ($urandom_range(0, 7) == 0) ? 3 : 0);
        end

        txn(1, 37'(BASE + 3), 28'h5A5A5A5, 0);
        @(negedge clk);
        req_valid = 1; req_wr = 1; req_addr = 37'(BASE + 3); req_wdata = 28'h0F0F0F0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("rstw_accept", 64'(n < 20), 1);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rstw_cfg_reg0", 64'(cfg_reg0), 0);
        chk("rstw_err_count", 64'(err_count), 0);
        chk("rstw_rsp_valid", 64'(rsp_valid), 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        n = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) n++; end
        chk("rstw_no_rsp", 64'(n), 0);
        txn(0, 37'(BASE + 3), 28'h0, 0);

        for (int i = 0; i < 260; i++) txn(0, 37'(BASE + NR + $urandom_range(0, 1000)), 28'h0, 0);
        chk("err_saturated", 64'(err_count), 255);

        for (int i = 0; i < NR; i++) ztxn(1, 37'(BASE + i), 28'(i), 28'h0);
        for (int i = 0; i < NR; i++) ztxn(0, 37'(BASE + i), 28'h0, 28'(i));
        chk("z_err_count", 64'(z_err_count), 0);
        chk("z_cfg_reg0", 64'(z_cfg_reg0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
